// File: rtl/matrix_store.sv
`default_nettype none
// ============================================================================
// Module   : matrix_store
// Desc     : Slot-based matrix buffer. Groups matrices by (m,n), evicts the
//            oldest of a group at quota, serves indexed reads by slot scan.
//            Optional build macro MATRIX_STORE_OCC_EN adds `occupancy`.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_store #(
    parameter int NUM_SLOTS = 8,
    parameter int DATA_W    = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_en,
    input  logic [3:0]        mat_m,
    input  logic [3:0]        mat_n,
    input  logic [DATA_W-1:0] mat_data_flat,
    input  logic [3:0]        max_mat_num,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [3:0]        rd_m,
    input  logic [3:0]        rd_n,
    input  logic [3:0]        rd_idx,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    output logic [3:0]        rd_total,
    output logic              wr_done,
    output logic              err_dim,
    output logic              err_full,
`ifdef MATRIX_STORE_OCC_EN
    output logic [4:0]        occupancy,
`endif
    output logic              err_ovf
);

    localparam int                 c_IDX_W = $clog2(NUM_SLOTS);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WR_COMMIT = 2'd1,
        S_RD_SCAN   = 2'd2,
        S_RD_DONE   = 2'd3
    } state_t;

    state_t               r_state_q, w_state_d;

    logic [NUM_SLOTS-1:0] r_valid_q, w_valid_d;
    logic [3:0]           r_m_q    [NUM_SLOTS];
    logic [3:0]           w_m_d    [NUM_SLOTS];
    logic [3:0]           r_n_q    [NUM_SLOTS];
    logic [3:0]           w_n_d    [NUM_SLOTS];
    logic [3:0]           r_rank_q [NUM_SLOTS];
    logic [3:0]           w_rank_d [NUM_SLOTS];
    logic [DATA_W-1:0]    r_data_q [NUM_SLOTS];
    logic [DATA_W-1:0]    w_data_d [NUM_SLOTS];

    logic                 r_pend_vld_q, w_pend_vld_d;
    logic [3:0]           r_pend_m_q, w_pend_m_d;
    logic [3:0]           r_pend_n_q, w_pend_n_d;
    logic [DATA_W-1:0]    r_pend_data_q, w_pend_data_d;

    logic [3:0]           r_req_m_q, w_req_m_d;
    logic [3:0]           r_req_n_q, w_req_n_d;
    logic [3:0]           r_req_idx_q, w_req_idx_d;
    logic [c_IDX_W-1:0]   r_scan_q, w_scan_d;
    logic [3:0]           r_cnt_q, w_cnt_d;
    logic                 r_hit_q, w_hit_d;
    logic [DATA_W-1:0]    r_acc_q, w_acc_d;

    logic                 r_rd_ready_q, w_rd_ready_d;
    logic                 r_rd_valid_q, w_rd_valid_d;
    logic                 r_rd_hit_q, w_rd_hit_d;
    logic [DATA_W-1:0]    r_rd_data_q, w_rd_data_d;
    logic [3:0]           r_rd_total_q, w_rd_total_d;
    logic                 r_wr_done_q, w_wr_done_d;
    logic                 r_err_dim_q, w_err_dim_d;
    logic                 r_err_full_q, w_err_full_d;
    logic                 r_err_ovf_q, w_err_ovf_d;

    logic [4:0]           w_grp_cnt;
    logic [4:0]           w_quota;
    logic                 w_dim_ok;
    logic                 w_free_found;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic                 w_old_found;
    logic [c_IDX_W-1:0]   w_old_idx;
    logic                 w_scan_match;

    // Group census for the pending write: member count, oldest member, first free slot
    always_comb begin
        w_grp_cnt    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_old_found  = 1'b0;
        w_old_idx    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_valid_q[i] && r_m_q[i] == r_pend_m_q && r_n_q[i] == r_pend_n_q) begin
                w_grp_cnt = w_grp_cnt + 5'd1;
                if (!w_old_found && r_rank_q[i] == 4'd0) begin
                    w_old_found = 1'b1;
                    w_old_idx   = c_IDX_W'(i);
                end
            end
            if (!r_valid_q[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
        end
    end

    assign w_quota  = (max_mat_num == 4'd0) ? 5'd1 : {1'b0, max_mat_num};
    assign w_dim_ok = (r_pend_m_q >= 4'd1) && (r_pend_m_q <= 4'd5) &&
                      (r_pend_n_q >= 4'd1) && (r_pend_n_q <= 4'd5);
    assign w_scan_match = r_valid_q[r_scan_q] &&
                          r_m_q[r_scan_q] == r_req_m_q && r_n_q[r_scan_q] == r_req_n_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_valid_d     = r_valid_q;
        w_m_d         = r_m_q;
        w_n_d         = r_n_q;
        w_rank_d      = r_rank_q;
        w_data_d      = r_data_q;
        w_pend_vld_d  = r_pend_vld_q;
        w_pend_m_d    = r_pend_m_q;
        w_pend_n_d    = r_pend_n_q;
        w_pend_data_d = r_pend_data_q;
        w_req_m_d     = r_req_m_q;
        w_req_n_d     = r_req_n_q;
        w_req_idx_d   = r_req_idx_q;
        w_scan_d      = r_scan_q;
        w_cnt_d       = r_cnt_q;
        w_hit_d       = r_hit_q;
        w_acc_d       = r_acc_q;
        w_rd_valid_d  = 1'b0;
        w_rd_hit_d    = r_rd_hit_q;
        w_rd_data_d   = r_rd_data_q;
        w_rd_total_d  = r_rd_total_q;
        w_wr_done_d   = 1'b0;
        w_err_dim_d   = 1'b0;
        w_err_full_d  = 1'b0;
        w_err_ovf_d   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (r_pend_vld_q) begin
                    w_state_d = S_WR_COMMIT;
                end else if (rd_req && r_rd_ready_q) begin
                    w_req_m_d   = rd_m;
                    w_req_n_d   = rd_n;
                    w_req_idx_d = rd_idx;
                    w_scan_d    = '0;
                    w_cnt_d     = '0;
                    w_hit_d     = 1'b0;
                    w_acc_d     = '0;
                    w_state_d   = S_RD_SCAN;
                end
            end
            S_WR_COMMIT: begin
                w_state_d    = S_IDLE;
                w_pend_vld_d = 1'b0;
                if (!w_dim_ok) begin
                    w_err_dim_d = 1'b1;
                end else if (w_grp_cnt >= w_quota) begin
                    // Replace the oldest member; everyone else in the group ages by one
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (r_valid_q[i] && r_m_q[i] == r_pend_m_q && r_n_q[i] == r_pend_n_q &&
                            c_IDX_W'(i) != w_old_idx && r_rank_q[i] != 4'd0) begin
                            w_rank_d[i] = r_rank_q[i] - 4'd1;
                        end
                    end
                    w_data_d[w_old_idx] = r_pend_data_q;
                    w_rank_d[w_old_idx] = w_grp_cnt[3:0] - 4'd1;
                    w_wr_done_d         = 1'b1;
                end else if (w_free_found) begin
                    w_valid_d[w_free_idx] = 1'b1;
                    w_m_d[w_free_idx]     = r_pend_m_q;
                    w_n_d[w_free_idx]     = r_pend_n_q;
                    w_data_d[w_free_idx]  = r_pend_data_q;
                    w_rank_d[w_free_idx]  = w_grp_cnt[3:0];
                    w_wr_done_d           = 1'b1;
                end else begin
                    w_err_full_d = 1'b1;
                end
            end
            S_RD_SCAN: begin
                w_cnt_d = r_cnt_q + {3'b000, w_scan_match};
                if (w_scan_match && r_rank_q[r_scan_q] == r_req_idx_q) begin
                    w_hit_d = 1'b1;
                    w_acc_d = r_data_q[r_scan_q];
                end
                if (r_scan_q == c_LAST) begin
                    w_state_d    = S_RD_DONE;
                    w_rd_valid_d = 1'b1;
                    w_rd_hit_d   = w_hit_d;
                    w_rd_data_d  = w_acc_d;
                    w_rd_total_d = w_cnt_d;
                end else begin
                    w_scan_d = r_scan_q + c_IDX_W'(1);
                end
            end
            S_RD_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Pending buffer is one deep; a strobe that finds it occupied is lost
        if (store_en) begin
            if (!r_pend_vld_q) begin
                w_pend_vld_d  = 1'b1;
                w_pend_m_d    = mat_m;
                w_pend_n_d    = mat_n;
                w_pend_data_d = mat_data_flat;
            end else begin
                w_err_ovf_d = 1'b1;
            end
        end

        if (clear) begin
            w_valid_d    = '0;
            w_pend_vld_d = 1'b0;
            w_state_d    = S_IDLE;
            w_rd_valid_d = 1'b0;
            w_rd_hit_d   = r_rd_hit_q;
            w_rd_data_d  = r_rd_data_q;
            w_rd_total_d = r_rd_total_q;
            w_wr_done_d  = 1'b0;
            w_err_dim_d  = 1'b0;
            w_err_full_d = 1'b0;
            w_err_ovf_d  = 1'b0;
        end

        w_rd_ready_d = (w_state_d == S_IDLE) && !w_pend_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_valid_q     <= '0;
            r_m_q         <= '{default: '0};
            r_n_q         <= '{default: '0};
            r_rank_q      <= '{default: '0};
            r_data_q      <= '{default: '0};
            r_pend_vld_q  <= 1'b0;
            r_pend_m_q    <= '0;
            r_pend_n_q    <= '0;
            r_pend_data_q <= '0;
            r_req_m_q     <= '0;
            r_req_n_q     <= '0;
            r_req_idx_q   <= '0;
            r_scan_q      <= '0;
            r_cnt_q       <= '0;
            r_hit_q       <= 1'b0;
            r_acc_q       <= '0;
            r_rd_ready_q  <= 1'b0;
            r_rd_valid_q  <= 1'b0;
            r_rd_hit_q    <= 1'b0;
            r_rd_data_q   <= '0;
            r_rd_total_q  <= '0;
            r_wr_done_q   <= 1'b0;
            r_err_dim_q   <= 1'b0;
            r_err_full_q  <= 1'b0;
            r_err_ovf_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_valid_q     <= w_valid_d;
            r_m_q         <= w_m_d;
            r_n_q         <= w_n_d;
            r_rank_q      <= w_rank_d;
            r_data_q      <= w_data_d;
            r_pend_vld_q  <= w_pend_vld_d;
            r_pend_m_q    <= w_pend_m_d;
            r_pend_n_q    <= w_pend_n_d;
            r_pend_data_q <= w_pend_data_d;
            r_req_m_q     <= w_req_m_d;
            r_req_n_q     <= w_req_n_d;
            r_req_idx_q   <= w_req_idx_d;
            r_scan_q      <= w_scan_d;
            r_cnt_q       <= w_cnt_d;
            r_hit_q       <= w_hit_d;
            r_acc_q       <= w_acc_d;
            r_rd_ready_q  <= w_rd_ready_d;
            r_rd_valid_q  <= w_rd_valid_d;
            r_rd_hit_q    <= w_rd_hit_d;
            r_rd_data_q   <= w_rd_data_d;
            r_rd_total_q  <= w_rd_total_d;
            r_wr_done_q   <= w_wr_done_d;
            r_err_dim_q   <= w_err_dim_d;
            r_err_full_q  <= w_err_full_d;
            r_err_ovf_q   <= w_err_ovf_d;
        end
    end

`ifdef MATRIX_STORE_OCC_EN
    logic [4:0] r_occ_q, w_occ_d;

    always_comb begin
        w_occ_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_occ_d = w_occ_d + {4'b0000, w_valid_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ_q <= '0;
        end else begin
            r_occ_q <= w_occ_d;
        end
    end

    assign occupancy = r_occ_q;
`else
    // occupancy counter not built
`endif

    assign rd_ready = r_rd_ready_q;
    assign rd_valid = r_rd_valid_q;
    assign rd_hit   = r_rd_hit_q;
    assign rd_data  = r_rd_data_q;
    assign rd_total = r_rd_total_q;
    assign wr_done  = r_wr_done_q;
    assign err_dim  = r_err_dim_q;
    assign err_full = r_err_full_q;
    assign err_ovf  = r_err_ovf_q;

endmodule
`default_nettype wire
